// File: rtl/floo_sl_iso_pkg.sv
// Shared types for the serial-link isolation controller.
// Bit positions match the link's 2-bit isolate vector.
package floo_sl_iso_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    ISO
  } iso_state_e;

  localparam int unsigned IsoIngress = 0;
  localparam int unsigned IsoEgress  = 1;

endpackage

// File: rtl/floo_sl_iso_gate.sv
// One direction of the isolation controller: FSM, packet-boundary tracking, valid/ready gating.
// Optional drain timeout enabled by FLOO_SL_ISO_TIMEOUT_EN.
module floo_sl_iso_gate
  import floo_sl_iso_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_i,
  input  logic drain_ok_i,
  input  logic force_gate_i,
  input  logic in_valid_i,
  input  logic in_last_i,
  output logic in_ready_o,
  output logic out_valid_o,
  input  logic out_ready_i,
  output logic fire_o,
  output logic isolated_o,
  output logic timeout_o,
  output logic timeout_pulse_o
);

  iso_state_e r_state, w_state_nxt;
  logic       r_mid_pkt, r_pend, r_isolated;
  logic       w_boundary, w_gate, w_timeout;

  // Gating only ever starts between packets and with no valid left hanging.
  assign w_boundary  = ~r_mid_pkt & ~r_pend;
  assign w_gate      = (r_state == ISO) |
                       (w_boundary & ((r_state == DRAIN) | force_gate_i));
  assign out_valid_o = in_valid_i & ~w_gate;
  assign in_ready_o  = out_ready_i & ~w_gate;
  assign fire_o      = out_valid_o & out_ready_i;
  assign isolated_o  = r_isolated;

`ifdef FLOO_SL_ISO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_timeout;

  assign w_timeout       = (r_state == DRAIN) && (r_tcnt == TW'(TimeoutCycles - 1));
  assign timeout_o       = r_timeout;
  assign timeout_pulse_o = w_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tcnt    <= (r_state == DRAIN && w_state_nxt == DRAIN) ? r_tcnt + TW'(1) : '0;
      r_timeout <= r_timeout | w_timeout;
    end
  end
`else
  assign w_timeout       = 1'b0;
  assign timeout_o       = 1'b0;
  assign timeout_pulse_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACTIVE: if (isolate_i) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!isolate_i)                                 w_state_nxt = ACTIVE;
        else if ((w_boundary & drain_ok_i) | w_timeout) w_state_nxt = ISO;
      end
      ISO:     if (!isolate_i) w_state_nxt = ACTIVE;
      default: w_state_nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ACTIVE;
      r_mid_pkt  <= 1'b0;
      r_pend     <= 1'b0;
      r_isolated <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= out_valid_o & ~out_ready_i;
      // A timed-out drain abandons the packet in flight.
      if (w_timeout)   r_mid_pkt <= 1'b0;
      else if (fire_o) r_mid_pkt <= ~in_last_i;
      r_isolated <= (r_state == ISO) && (w_state_nxt == ISO);
    end
  end

endmodule

// File: rtl/floo_sl_isolation_ctrl.sv
// Isolate/isolated handshake in front of the floo serial link: zero-latency pass-through,
// outstanding-packet tracking, per-direction drain. Optional timeout: FLOO_SL_ISO_TIMEOUT_EN.
module floo_sl_isolation_ctrl
  import floo_sl_iso_pkg::*;
#(
  parameter type         req_flit_t     = logic,
  parameter type         rsp_flit_t     = logic,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned TimeoutCycles  = 1024,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          isolate_i,
  output logic [1:0]          isolated_o,
  input  logic                noc_req_valid_i,
  output logic                noc_req_ready_o,
  input  req_flit_t           noc_req_i,
  input  logic                noc_req_last_i,
  output logic                sl_req_valid_o,
  input  logic                sl_req_ready_i,
  output req_flit_t           sl_req_o,
  input  logic                sl_rsp_valid_i,
  output logic                sl_rsp_ready_o,
  input  rsp_flit_t           sl_rsp_i,
  input  logic                sl_rsp_last_i,
  output logic                noc_rsp_valid_o,
  input  logic                noc_rsp_ready_i,
  output rsp_flit_t           noc_rsp_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                err_underflow_o,
  output logic                timeout_o
);

  logic [CntWidth-1:0] r_cnt, w_cnt_nxt;
  logic                r_underflow, w_uflow, w_inc, w_dec;
  logic [1:0]          w_fire, w_timeout, w_to_pulse;

  assign sl_req_o  = noc_req_i;
  assign noc_rsp_o = sl_rsp_i;

  floo_sl_iso_gate #(.TimeoutCycles(TimeoutCycles)) u_gate_ingress (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .isolate_i       (isolate_i[IsoIngress]),
    .drain_ok_i      (1'b1),
    .force_gate_i    (1'b0),
    .in_valid_i      (sl_rsp_valid_i),
    .in_last_i       (sl_rsp_last_i),
    .in_ready_o      (sl_rsp_ready_o),
    .out_valid_o     (noc_rsp_valid_o),
    .out_ready_i     (noc_rsp_ready_i),
    .fire_o          (w_fire[IsoIngress]),
    .isolated_o      (isolated_o[IsoIngress]),
    .timeout_o       (w_timeout[IsoIngress]),
    .timeout_pulse_o (w_to_pulse[IsoIngress])
  );

  // Egress may only isolate with nothing in flight, and stalls at packet
  // boundaries while the response budget is exhausted.
  floo_sl_iso_gate #(.TimeoutCycles(TimeoutCycles)) u_gate_egress (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .isolate_i       (isolate_i[IsoEgress]),
    .drain_ok_i      (r_cnt == '0),
    .force_gate_i    (r_cnt == CntWidth'(MaxOutstanding)),
    .in_valid_i      (noc_req_valid_i),
    .in_last_i       (noc_req_last_i),
    .in_ready_o      (noc_req_ready_o),
    .out_valid_o     (sl_req_valid_o),
    .out_ready_i     (sl_req_ready_i),
    .fire_o          (w_fire[IsoEgress]),
    .isolated_o      (isolated_o[IsoEgress]),
    .timeout_o       (w_timeout[IsoEgress]),
    .timeout_pulse_o (w_to_pulse[IsoEgress])
  );

  assign w_inc = w_fire[IsoEgress] & noc_req_last_i;
  assign w_dec = w_fire[IsoIngress] & sl_rsp_last_i;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_uflow   = 1'b0;
    if (|w_to_pulse) begin
      w_cnt_nxt = '0;
    end else if (w_inc & ~w_dec) begin
      w_cnt_nxt = r_cnt + CntWidth'(1);
    end else if (w_dec & ~w_inc) begin
      if (r_cnt == '0) w_uflow = 1'b1;
      else             w_cnt_nxt = r_cnt - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_underflow <= r_underflow | w_uflow;
    end
  end

  assign outstanding_o   = r_cnt;
  assign err_underflow_o = r_underflow;
  assign timeout_o       = |w_timeout;

endmodule

// File: tb/tb_floo_sl_isolation_ctrl.sv
// Directed bench for floo_sl_isolation_ctrl; timeout scenario only when FLOO_SL_ISO_TIMEOUT_EN is defined.
module tb_floo_sl_isolation_ctrl;

  localparam int unsigned MaxOut = 16;
`ifdef FLOO_SL_ISO_TIMEOUT_EN
  localparam int unsigned ToCyc = 8;
`else
  localparam int unsigned ToCyc = 1024;
`endif

  typedef logic [31:0] flit_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] isolate_i, isolated_o;
  logic       noc_req_valid_i, noc_req_ready_o, noc_req_last_i;
  logic       sl_req_valid_o, sl_req_ready_i;
  logic       sl_rsp_valid_i, sl_rsp_ready_o, sl_rsp_last_i;
  logic       noc_rsp_valid_o, noc_rsp_ready_i;
  flit_t      noc_req_i, sl_req_o, sl_rsp_i, noc_rsp_o;
  logic [4:0] outstanding_o;
  logic       err_underflow_o, timeout_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  floo_sl_isolation_ctrl #(
    .req_flit_t     (flit_t),
    .rsp_flit_t     (flit_t),
    .MaxOutstanding (MaxOut),
    .TimeoutCycles  (ToCyc)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .isolate_i       (isolate_i),
    .isolated_o      (isolated_o),
    .noc_req_valid_i (noc_req_valid_i),
    .noc_req_ready_o (noc_req_ready_o),
    .noc_req_i       (noc_req_i),
    .noc_req_last_i  (noc_req_last_i),
    .sl_req_valid_o  (sl_req_valid_o),
    .sl_req_ready_i  (sl_req_ready_i),
    .sl_req_o        (sl_req_o),
    .sl_rsp_valid_i  (sl_rsp_valid_i),
    .sl_rsp_ready_o  (sl_rsp_ready_o),
    .sl_rsp_i        (sl_rsp_i),
    .sl_rsp_last_i   (sl_rsp_last_i),
    .noc_rsp_valid_o (noc_rsp_valid_o),
    .noc_rsp_ready_i (noc_rsp_ready_i),
    .noc_rsp_o       (noc_rsp_o),
    .outstanding_o   (outstanding_o),
    .err_underflow_o (err_underflow_o),
    .timeout_o       (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One flit presented for one cycle; must be accepted at the coming edge.
  task automatic send_req(input flit_t d, input logic last);
    noc_req_valid_i = 1'b1;
    noc_req_i       = d;
    noc_req_last_i  = last;
    #1;
    chk("req_data", sl_req_o, d);
    chk("req_vld", sl_req_valid_o, 1);
    chk("req_rdy", noc_req_ready_o, 1);
    tick();
    noc_req_valid_i = 1'b0;
  endtask

  task automatic send_rsp(input flit_t d, input logic last);
    sl_rsp_valid_i = 1'b1;
    sl_rsp_i       = d;
    sl_rsp_last_i  = last;
    #1;
    chk("rsp_data", noc_rsp_o, d);
    chk("rsp_vld", noc_rsp_valid_o, 1);
    chk("rsp_rdy", sl_rsp_ready_o, 1);
    tick();
    sl_rsp_valid_i = 1'b0;
  endtask

  task automatic wait_iso(input logic [1:0] exp, input int bound, input string tag);
    int k = 0;
    while (isolated_o !== exp && k < bound) begin
      tick();
      k++;
    end
    chk(tag, isolated_o, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; isolate_i = 2'b00;
    noc_req_valid_i = 1'b0; noc_req_i = '0; noc_req_last_i = 1'b1; sl_req_ready_i = 1'b1;
    sl_rsp_valid_i = 1'b0; sl_rsp_i = '0; sl_rsp_last_i = 1'b1; noc_rsp_ready_i = 1'b1;
    repeat (2) tick();
    chk("rst_isolated", isolated_o, 0);
    chk("rst_cnt", outstanding_o, 0);
    chk("rst_err", err_underflow_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_i = 1'b0;
    tick();

    // Plain pass-through, counter up and down
    for (int i = 0; i < 3; i++) begin
      send_req(32'hA000_0000 + i, 1'b1);
      chk("pt_cnt_up", outstanding_o, i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      send_rsp(32'hB000_0000 + i, 1'b1);
      chk("pt_cnt_dn", outstanding_o, 2 - i);
    end
    chk("pt_isolated", isolated_o, 0);

    // Isolate mid-packet: the packet completes, then egress gates and waits for the response
    send_req(32'hC1, 1'b0);
    send_req(32'hC2, 1'b0);
    isolate_i = 2'b10;
    send_req(32'hC3, 1'b0);
    send_req(32'hC4, 1'b1);
    chk("mp_cnt", outstanding_o, 1);
    noc_req_valid_i = 1'b1; noc_req_last_i = 1'b1; #1;
    chk("mp_gate_rdy", noc_req_ready_o, 0);
    chk("mp_gate_vld", sl_req_valid_o, 0);
    noc_req_valid_i = 1'b0;
    repeat (3) tick();
    chk("mp_wait_iso", isolated_o, 0);
    send_rsp(32'hD1, 1'b1);
    chk("mp_cnt0", outstanding_o, 0);
    wait_iso(2'b10, 4, "mp_iso");

    // Release from ISO: flows again next cycle
    isolate_i = 2'b00;
    tick();
    chk("rel_iso", isolated_o, 0);
    send_req(32'hE1, 1'b1);
    send_rsp(32'hE2, 1'b1);
    chk("rel_cnt", outstanding_o, 0);

    // A valid already shown to the link is held through the drain
    sl_req_ready_i = 1'b0; noc_req_valid_i = 1'b1; noc_req_i = 32'hF1; noc_req_last_i = 1'b1;
    tick();
    isolate_i = 2'b10;
    tick();
    chk("pd_vld", sl_req_valid_o, 1);
    chk("pd_rdy", noc_req_ready_o, 0);
    tick();
    chk("pd_vld2", sl_req_valid_o, 1);
    sl_req_ready_i = 1'b1; #1;
    chk("pd_fire_rdy", noc_req_ready_o, 1);
    tick();
    chk("pd_gated_vld", sl_req_valid_o, 0);
    chk("pd_gated_rdy", noc_req_ready_o, 0);
    chk("pd_cnt", outstanding_o, 1);
    noc_req_valid_i = 1'b0; isolate_i = 2'b00;
    tick();
    send_rsp(32'hF2, 1'b1);
    chk("pd_cnt0", outstanding_o, 0);

    // Credit limit
    for (int i = 0; i < 16; i++) send_req(32'h100 + i, 1'b1);
    chk("cr_cnt16", outstanding_o, 16);
    noc_req_valid_i = 1'b1; noc_req_i = 32'h1FF; noc_req_last_i = 1'b1; #1;
    chk("cr_stall_rdy", noc_req_ready_o, 0);
    chk("cr_stall_vld", sl_req_valid_o, 0);
    tick();
    chk("cr_stall_rdy2", noc_req_ready_o, 0);
    sl_rsp_valid_i = 1'b1; sl_rsp_last_i = 1'b1; #1;
    chk("cr_rsp_rdy", sl_rsp_ready_o, 1);
    tick();
    sl_rsp_valid_i = 1'b0;
    chk("cr_cnt15", outstanding_o, 15);
    chk("cr_rel_rdy", noc_req_ready_o, 1);
    chk("cr_rel_data", sl_req_o, 32'h1FF);
    tick();
    noc_req_valid_i = 1'b0;
    chk("cr_cnt16b", outstanding_o, 16);
    for (int i = 0; i < 16; i++) send_rsp(32'h180 + i, 1'b1);
    chk("cr_cnt0", outstanding_o, 0);

    // Underflow, then simultaneous increment and decrement
    chk("uf_pre", err_underflow_o, 0);
    send_rsp(32'h200, 1'b1);
    chk("uf_err", err_underflow_o, 1);
    chk("uf_cnt", outstanding_o, 0);
    for (int i = 0; i < 5; i++) send_req(32'h210 + i, 1'b1);
    chk("sim_pre", outstanding_o, 5);
    noc_req_valid_i = 1'b1; noc_req_last_i = 1'b1; sl_rsp_valid_i = 1'b1; sl_rsp_last_i = 1'b1; #1;
    chk("sim_req_rdy", noc_req_ready_o, 1);
    chk("sim_rsp_rdy", sl_rsp_ready_o, 1);
    tick();
    noc_req_valid_i = 1'b0; sl_rsp_valid_i = 1'b0;
    chk("sim_cnt", outstanding_o, 5);
    chk("uf_sticky", err_underflow_o, 1);

    // Reset in the middle of an egress drain
    send_req(32'h300, 1'b0);
    isolate_i = 2'b10;
    tick();
    noc_req_valid_i = 1'b1; noc_req_last_i = 1'b0; #1;
    chk("rd_midpkt_rdy", noc_req_ready_o, 1);
    rst_i = 1'b1; #1;
    chk("rd_cnt", outstanding_o, 0);
    chk("rd_err", err_underflow_o, 0);
    chk("rd_iso", isolated_o, 0);
    noc_req_valid_i = 1'b0; isolate_i = 2'b00;
    tick();
    rst_i = 1'b0;
    tick();
    send_req(32'h310, 1'b1);
    chk("rd_cnt1", outstanding_o, 1);
    send_rsp(32'h311, 1'b1);
    isolate_i = 2'b10;
    wait_iso(2'b10, 6, "rd_iso_clean");
    isolate_i = 2'b00;
    tick();
    chk("rd_rel", isolated_o, 0);

`ifdef FLOO_SL_ISO_TIMEOUT_EN
    // Drain with a response that never arrives
    send_req(32'h400, 1'b1);
    isolate_i = 2'b10;
    repeat (4) tick();
    chk("to_early", isolated_o, 0);
    wait_iso(2'b10, 20, "to_iso");
    chk("to_flag", timeout_o, 1);
    chk("to_cnt", outstanding_o, 0);
    isolate_i = 2'b00;
    tick();
`else
    chk("to_off", timeout_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/floo_sl_isolation_ctrl.md
Name: floo_sl_isolation_ctrl

Overview:
Sits directly upstream of the floo serial link on the NoC side. It implements the serial link's isolate/isolated handshake, which is currently unconnected in the link wrapper.
- Passes req flits (NoC→link, egress) and rsp flits (link→NoC, ingress) through with zero latency.
- Counts outstanding egress packets awaiting responses.
- On an isolate request, gates each direction cleanly at packet boundaries, drains, then reports isolated.
- isolate_i/isolated_o bit 0 = ingress (rsp), bit 1 = egress (req), matching the link's 2-bit isolate vector.

Parameters:
req_flit_t, logic, request flit payload type
rsp_flit_t, logic, response flit payload type
MaxOutstanding, 16, max egress packets awaiting a response (>=1)
CntWidth, $clog2(MaxOutstanding+1), outstanding counter width (derived, not overridable)
TimeoutCycles, 1024, drain timeout (used only with optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
isolate_i  in  2  isolate request per direction [0]=ingress, [1]=egress
isolated_o  out  2  isolation acknowledged per direction
noc_req_valid_i / noc_req_ready_o / noc_req_i / noc_req_last_i  in/out/in/in  1/1/req_flit_t/1  egress flits from NoC
sl_req_valid_o / sl_req_ready_i / sl_req_o  out/in/out  1/1/req_flit_t  egress flits to serial link
sl_rsp_valid_i / sl_rsp_ready_o / sl_rsp_i / sl_rsp_last_i  in/out/in/in  1/1/rsp_flit_t/1  ingress flits from serial link
noc_rsp_valid_o / noc_rsp_ready_i / noc_rsp_o  out/in/out  1/1/rsp_flit_t  ingress flits to NoC
outstanding_o  out  CntWidth  current outstanding packet count
err_underflow_o  out  1  sticky: response last received with count 0
timeout_o  out  1  sticky drain timeout (optional feature only; tied 0 otherwise)

Behaviour:
- Data paths are combinational: sl_req_o=noc_req_i, noc_rsp_o=sl_rsp_i. No flit is stored.
- Handshake: fire = valid & ready on a side.
- Each direction has an FSM {ACTIVE, DRAIN, ISO}, a mid_pkt flag and a pend flag.
  - mid_pkt: set on a fire with last=0, cleared on a fire with last=1.
  - pend: output valid shown last cycle without fire. Gating never drops an already presented valid.
- ACTIVE: pass valid/ready through. isolate_i[d]=1 → DRAIN.
- DRAIN:
  - While mid_pkt or pend: keep passing, so the packet and any pending valid complete.
  - Once !mid_pkt & !pend: gate. Output valid=0 and input ready=0 from the next cycle.
  - Egress → ISO when gated & outstanding==0. Ingress → ISO when gated.
  - isolate_i[d] deasserted in DRAIN → ACTIVE next cycle.
- ISO: gated. isolated_o[d]=1 (registered, asserts the cycle after entering ISO). isolate_i[d]=0 → ACTIVE, isolated_o drops the same cycle ACTIVE is entered.
- Outstanding counter:
  - +1 on egress fire with last=1; −1 on ingress fire with last=1; both in one cycle → unchanged.
  - count==MaxOutstanding: egress gated at packet boundary exactly as in DRAIN; release when count drops.
  - Decrement at 0: count stays 0, err_underflow_o set sticky until reset.
- Ingress keeps accepting responses in egress DRAIN. That is what allows the count to drain.
- Reset (any time, including mid-packet): FSMs ACTIVE, mid_pkt=pend=0, count=0, isolated_o=2'b00, error flags 0. All valid/ready outputs follow the inputs combinationally (ACTIVE).

Optional Feature:
FLOO_SL_ISO_TIMEOUT_EN
- Defined: a per-direction counter runs while in DRAIN and clears on leaving DRAIN. On reaching TimeoutCycles: force ISO, set timeout_o sticky, reset count to 0.
- Undefined: no counter; DRAIN waits indefinitely; timeout_o tied 0.

Decomposition:
- Package floo_sl_iso_pkg: iso_state_e {ACTIVE, DRAIN, ISO}; localparams IsoIngress=0, IsoEgress=1.
- Sub-module floo_sl_iso_gate: one direction's FSM, mid_pkt/pend tracking, valid/ready gating, optional timeout. Instantiated twice; the egress instance gets extra drain-condition and force-gate inputs driven by the counter.
- The outstanding counter lives in the top.

Test Plan:
- Pass-through: 3 single-flit req packets, 3 rsp packets, isolate=0 → payloads unchanged, outstanding_o goes 1,2,3 then back to 0; isolated_o=00 throughout.
- Mid-packet isolate: 4-flit req packet, isolate_i[1]=1 after flit 2 → flits 3–4 pass; noc_req_ready_o=0 after last; isolated_o[1] stays 0 until 1 rsp last arrives, then =1 next cycle.
- Pending valid: sl_req_ready_i=0 with valid shown, isolate_i[1]=1 → sl_req_valid_o stays 1 until ready; gating starts after the fire.
- Credit limit: MaxOutstanding=16, send 17 single-flit packets, no rsp → 17th stalls (ready=0); one rsp → 17th fires, count=16.
- Underflow and simultaneous events: rsp last at count=0 → err_underflow_o=1, count 0; same-cycle req last and rsp last at count 5 → count stays 5.
- Reset mid-DRAIN, then release: rst_i pulse during egress DRAIN → all state cleared, isolated_o=00, flits pass. Separately, from ISO, isolate_i→0 → ACTIVE and flits flow next cycle. With FLOO_SL_ISO_TIMEOUT_EN, TimeoutCycles=8 and no rsp → isolated_o[1]=1 and timeout_o=1 after 8 DRAIN cycles.
